// File: rtl/stack_exec_if.sv
// stack_exec_if: request/status bundle between the selection decoder and the stack executor.
interface stack_exec_if #(parameter int DATA_W = 8);
    logic              valid;
    logic [1:0]        selector;
    logic [2:0]        op_code;
    logic [DATA_W-1:0] push_data;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] top_data;
    logic [2:0]        flags;
    modport master (output valid, selector, op_code, push_data, input ready, done, top_data, flags);
    modport slave (input valid, selector, op_code, push_data, output ready, done, top_data, flags);
endinterface

// File: rtl/stack_exec_unit.sv
// stack_exec_unit: LIFO executing push/pop/binary ALU requests with status flags.
// Define STACK_STICKY_ERR_EN to make the error flag hold until reset.
module stack_exec_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input logic         clk,
    input logic         rst,
    stack_exec_if.slave bus
);
    typedef enum logic [2:0] {IDLE, EXEC, ALU_RD, ALU_EX, ALU_WB} state_t;
    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W:0]    r_sp, w_sp_nxt;
    logic [1:0]        r_sel;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_din, r_b, r_res, r_top, w_top_nxt, w_a, w_res, w_wdata;
    logic              r_empty, r_full, r_err, r_done;
    logic              w_ready, w_fin, w_err, w_we, w_alu_go, w_ge2;
    logic [PTR_W-1:0]  w_m1, w_m2, w_waddr;

    assign w_m1     = r_sp[PTR_W-1:0] - PTR_W'(1);
    assign w_m2     = r_sp[PTR_W-1:0] - PTR_W'(2);
    assign w_ge2    = r_sp > (PTR_W+1)'(1);
    assign w_a      = r_mem[w_m2];
    assign w_alu_go = bus.selector == 2'b01 && bus.op_code != 3'b100 && bus.op_code != 3'b111 && w_ge2;
    assign w_res    = r_op == 3'b000 ? w_a + r_b :
                      r_op == 3'b001 ? w_a - r_b :
                      r_op == 3'b010 ? w_a & r_b :
                      r_op == 3'b011 ? w_a | r_b :
                      r_op == 3'b101 ? w_a ^ r_b :
                      r_op == 3'b110 ? ~(w_a & r_b) : '0;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = bus.valid ? (w_alu_go ? ALU_RD : EXEC) : IDLE;
            ALU_RD:  w_state_nxt = ALU_EX;
            ALU_EX:  w_state_nxt = ALU_WB;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ready = r_state == IDLE;
        w_fin   = r_state == EXEC || r_state == ALU_WB;
    end

    // Every stack/flag update is resolved here and committed on the done edge.
    always_comb begin
        w_sp_nxt  = r_sp;
        w_top_nxt = r_top;
        w_err     = 1'b0;
        w_we      = 1'b0;
        w_waddr   = r_sp[PTR_W-1:0];
        w_wdata   = r_din;
        if (r_state == ALU_WB) begin
            w_we      = 1'b1;
            w_waddr   = w_m2;
            w_wdata   = r_res;
            w_sp_nxt  = r_sp - (PTR_W+1)'(1);
            w_top_nxt = r_res;
        end else if (r_state == EXEC) begin
            case (r_sel)
                2'b01: w_err = 1'b1;
                2'b10: begin
                    w_err     = r_full;
                    w_we      = !r_full;
                    w_sp_nxt  = r_full ? r_sp : r_sp + (PTR_W+1)'(1);
                    w_top_nxt = r_full ? r_top : r_din;
                end
                2'b11: begin
                    w_err     = r_empty;
                    w_sp_nxt  = r_empty ? r_sp : r_sp - (PTR_W+1)'(1);
                    w_top_nxt = r_empty ? r_top : (w_ge2 ? r_mem[w_m2] : '0);
                end
                default: w_err = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we && !rst) r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp    <= '0;
            r_top   <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_sel   <= '0;
            r_op    <= '0;
            r_din   <= '0;
            r_b     <= '0;
            r_res   <= '0;
        end else begin
            r_done <= w_fin;
            if (w_fin) begin
                r_sp    <= w_sp_nxt;
                r_top   <= w_top_nxt;
                r_empty <= w_sp_nxt == '0;
                r_full  <= w_sp_nxt == (PTR_W+1)'(DEPTH);
`ifdef STACK_STICKY_ERR_EN
                r_err   <= r_err | w_err;
`else
                r_err   <= w_err;
`endif
            end
            if (w_ready && bus.valid) begin
                r_sel <= bus.selector;
                r_op  <= bus.op_code;
                r_din <= bus.push_data;
            end
            if (r_state == ALU_RD) r_b <= r_mem[w_m1];
            if (r_state == ALU_EX) r_res <= w_res;
        end
    end

    assign bus.ready    = w_ready;
    assign bus.done     = r_done;
    assign bus.top_data = r_top;
    assign bus.flags    = {r_err, r_full, r_empty};
endmodule

// File: tb/tb_stack_exec_unit.sv
// tb_stack_exec_unit: directed sequence with a reference stack model and an expected-result queue.
module tb_stack_exec_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_exec_if #(.DATA_W(8)) bus ();
    stack_exec_unit #(.DATA_W(8), .DEPTH(8), .PTR_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [7:0] top;
        logic [2:0] flags;
        int         lat;
    } exp_t;

    exp_t       q[$];
    logic [7:0] m[8];
    int         sp = 0;
    logic       err = 1'b0;
    logic [7:0] mtop = 8'h00;
    int         n_asserts = 0;
    int         n_fails = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [1:0] sel, input logic [2:0] op, input logic [7:0] d);
        logic       e;
        logic [7:0] a, b, r;
        exp_t       x;
        e = 1'b0;
        x.lat = 1;
        case (sel)
            2'b10: if (sp < 8) begin m[sp] = d; sp++; mtop = d; end else e = 1'b1;
            2'b11: if (sp > 0) begin sp--; mtop = sp > 0 ? m[sp-1] : 8'h00; end else e = 1'b1;
            2'b01: if (op == 3'd4 || op == 3'd7 || sp < 2) e = 1'b1;
                   else begin
                       a = m[sp-2];
                       b = m[sp-1];
                       case (op)
                           3'd0:    r = a + b;
                           3'd1:    r = a - b;
                           3'd2:    r = a & b;
                           3'd3:    r = a | b;
                           3'd5:    r = a ^ b;
                           default: r = ~(a & b);
                       endcase
                       m[sp-2] = r;
                       sp--;
                       mtop = r;
                       x.lat = 3;
                   end
            default: e = 1'b0;
        endcase
`ifdef STACK_STICKY_ERR_EN
        err = err | e;
`else
        err = e;
`endif
        x.top = mtop;
        x.flags = {err, 1'(sp == 8), 1'(sp == 0)};
        q.push_back(x);
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [2:0] op, input logic [7:0] d);
        bus.valid = v;
        bus.selector = sel;
        bus.op_code = op;
        bus.push_data = d;
    endtask

    task automatic wait_done(input int start);
        int   cyc;
        exp_t x;
        cyc = start;
        while (cyc < 10) begin
            step();
            cyc++;
            if (bus.done) break;
            chk("busy_ready", 32'(bus.ready), 32'(0));
        end
        chk("done_seen", 32'(bus.done), 32'(1));
        x = q.pop_front();
        chk("latency", 32'(cyc), 32'(x.lat));
        chk("top_data", 32'(bus.top_data), 32'(x.top));
        chk("flags", 32'(bus.flags), 32'(x.flags));
        chk("ready_at_done", 32'(bus.ready), 32'(1));
        step();
        chk("done_pulse", 32'(bus.done), 32'(0));
    endtask

    task automatic req(input logic [1:0] sel, input logic [2:0] op, input logic [7:0] d);
        model(sel, op, d);
        drive(1'b1, sel, op, d);
        step();
        drive(1'b0, 2'b00, 3'b000, 8'h00);
        wait_done(0);
    endtask

    initial begin
        drive(1'b0, 2'b00, 3'b000, 8'h00);
        step();
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("rst_ready", 32'(bus.ready), 32'(1));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_flags", 32'(bus.flags), 32'(3'b001));
        chk("rst_top", 32'(bus.top_data), 32'(0));

        req(2'b10, 3'd0, 8'h12);
        req(2'b10, 3'd0, 8'h34);
        req(2'b11, 3'd0, 8'h00);
        req(2'b11, 3'd0, 8'h00);
        req(2'b00, 3'd0, 8'h00);

        req(2'b10, 3'd0, 8'hF0);
        req(2'b10, 3'd0, 8'h20);
        req(2'b01, 3'd0, 8'h00);
        req(2'b11, 3'd0, 8'h00);
        req(2'b10, 3'd0, 8'h05);
        req(2'b10, 3'd0, 8'h07);
        req(2'b01, 3'd1, 8'h00);
        req(2'b11, 3'd0, 8'h00);

        for (int i = 1; i <= 8; i++) req(2'b10, 3'd0, 8'(i));
        req(2'b10, 3'd0, 8'hAA);
        for (int i = 0; i < 8; i++) req(2'b11, 3'd0, 8'h00);
        req(2'b11, 3'd0, 8'h00);

        req(2'b10, 3'd0, 8'h11);
        req(2'b10, 3'd0, 8'h22);
        req(2'b01, 3'd4, 8'h00);
        req(2'b01, 3'd7, 8'h00);
        req(2'b11, 3'd0, 8'h00);
        req(2'b01, 3'd0, 8'h00);
        req(2'b10, 3'd0, 8'h33);

        // A push offered while the ALU op is busy must be ignored.
        model(2'b01, 3'd0, 8'h00);
        drive(1'b1, 2'b01, 3'd0, 8'h00);
        step();
        drive(1'b1, 2'b10, 3'd0, 8'h99);
        step();
        chk("busy_ready", 32'(bus.ready), 32'(0));
        step();
        chk("busy_ready", 32'(bus.ready), 32'(0));
        drive(1'b0, 2'b00, 3'b000, 8'h00);
        wait_done(2);
        step();
        chk("ignored_done", 32'(bus.done), 32'(0));

        req(2'b10, 3'd0, 8'h0F);
        req(2'b01, 3'd2, 8'h00);
        req(2'b10, 3'd0, 8'h3C);
        req(2'b01, 3'd3, 8'h00);
        req(2'b10, 3'd0, 8'hA5);
        req(2'b01, 3'd5, 8'h00);
        req(2'b10, 3'd0, 8'h5A);
        req(2'b01, 3'd6, 8'h00);
        req(2'b10, 3'd0, 8'h55);

        // Reset lands while the ALU op is in ALU_EX.
        drive(1'b1, 2'b01, 3'd0, 8'h00);
        step();
        drive(1'b0, 2'b00, 3'b000, 8'h00);
        step();
        rst = 1'b1;
        step();
        chk("midrst_flags", 32'(bus.flags), 32'(3'b001));
        chk("midrst_top", 32'(bus.top_data), 32'(0));
        chk("midrst_done", 32'(bus.done), 32'(0));
        chk("midrst_ready", 32'(bus.ready), 32'(1));
        rst = 1'b0;
        sp = 0;
        err = 1'b0;
        mtop = 8'h00;
        repeat (3) begin
            step();
            chk("midrst_nodone", 32'(bus.done), 32'(0));
        end

        req(2'b11, 3'd0, 8'h00);
        req(2'b10, 3'd0, 8'h77);
        req(2'b10, 3'd0, 8'h78);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
